// File: rtl/neopixel_pixel_responder.sv
// rtl/neopixel_pixel_responder.sv - pixel store with single-cycle access and WS2812-style frame serializer
module neopixel_pixel_responder #(
    parameter int C_PIXELS = 12,
    parameter int C_T0H    = 50,
    parameter int C_T1H    = 100,
    parameter int C_TBIT   = 156,
    parameter int C_TRESET = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_readf,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int PW   = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
    localparam int TMAX = (C_TRESET > C_TBIT) ? C_TRESET : C_TBIT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T0H_LAST    = TW'(C_T0H - 1);
    localparam logic [TW-1:0] T1H_LAST    = TW'(C_T1H - 1);
    localparam logic [TW-1:0] TBIT_LAST   = TW'(C_TBIT - 1);
    localparam logic [TW-1:0] TRESET_LAST = TW'(C_TRESET - 1);
    localparam logic [31:0]   PIX_LIMIT   = 32'(C_PIXELS);
    localparam logic [PW-1:0] LAST_IDX    = PW'(C_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [23:0]   pixel_mem [C_PIXELS];
    logic [23:0]   shift;
    logic [4:0]    bit_cnt;
    logic [PW-1:0] pix_idx;
    logic [PW-1:0] pix_idx_inc;
    logic [TW-1:0] timer;
    logic          dirty;
    logic          addr_ok;
    logic [PW-1:0] addr_idx;
    logic          wr_en;
    logic          bit_last;

    assign addr_ok     = (address < PIX_LIMIT);
    assign addr_idx    = address[PW-1:0];
    assign wr_en       = write_readf && addr_ok;
    assign pix_idx_inc = pix_idx + 1'b1;
    assign bit_last    = (timer == TBIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (dirty) state_next = S_LOAD;
            S_LOAD:  state_next = S_HIGH;
            S_HIGH:  if (timer == (shift[23] ? T1H_LAST : T0H_LAST)) state_next = S_LOW;
            S_LOW: begin
                if (bit_last) begin
                    if (bit_cnt != 5'd0 || pix_idx != LAST_IDX) state_next = S_HIGH;
                    else                                         state_next = S_LATCH;
                end
            end
            S_LATCH: if (timer == TRESET_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign dout       = (state == S_HIGH);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_LATCH) && (timer == TRESET_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            pix_idx   <= '0;
            dirty     <= 1'b0;
            read_data <= '0;
            for (int i = 0; i < C_PIXELS; i++) pixel_mem[i] <= '0;
        end else begin
            state     <= state_next;
            read_data <= addr_ok ? {8'h00, pixel_mem[addr_idx]} : 32'h0;
            if (wr_en) pixel_mem[addr_idx] <= write_data[23:0];

            // A new write in the same cycle as the IDLE clear keeps dirty set
            if (wr_en)                          dirty <= 1'b1;
            else if (state == S_IDLE && dirty)  dirty <= 1'b0;

            // timer spans the whole bit period across HIGH and LOW
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (dirty) pix_idx <= '0;
                end
                S_LOAD: begin
                    shift   <= pixel_mem[pix_idx];
                    bit_cnt <= 5'd23;
                    timer   <= '0;
                end
                S_HIGH: timer <= timer + 1'b1;
                S_LOW: begin
                    if (bit_last) begin
                        timer <= '0;
                        if (bit_cnt != 5'd0) begin
                            shift   <= {shift[22:0], 1'b0};
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (pix_idx != LAST_IDX) begin
                            pix_idx <= pix_idx_inc;
                            shift   <= pixel_mem[pix_idx_inc];
                            bit_cnt <= 5'd23;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LATCH: timer <= timer + 1'b1;
                default: timer <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_pixel_responder.sv
// tb/tb_neopixel_pixel_responder.sv - directed self-checking bench for neopixel_pixel_responder
module tb_neopixel_pixel_responder;

    localparam int P          = 12;
    localparam int T0H        = 5;
    localparam int T1H        = 10;
    localparam int TBIT       = 16;
    localparam int TRESET     = 100;
    localparam int FRAME_LAST = P * 24 * TBIT + TRESET - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        write_readf = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        dout;
    logic        busy;
    logic        frame_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_pix [P];
    logic [23:0] got_pix [P];
    int          frame_len;
    int          timing_errs;
    int          rise_wait;

    neopixel_pixel_responder #(
        .C_PIXELS(P), .C_T0H(T0H), .C_T1H(T1H), .C_TBIT(TBIT), .C_TRESET(TRESET)
    ) dut (
        .clock(clock), .reset(reset), .write_readf(write_readf), .address(address),
        .write_data(write_data), .read_data(read_data), .dout(dout), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    // Measures a frame starting from the next dout rise; frame_len is the cycle index of frame_done
    task automatic capture_frame(output int flen, output int terrs, output int rwait);
        int h, l, t, guard;
        flen  = -1;
        terrs = 0;
        rwait = 0;
        while (dout !== 1'b1 && rwait < 200) begin
            rwait++;
            tick();
        end
        if (dout !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_start: dout=%b after %0d cycles, required 1", dout, rwait);
            return;
        end
        t = 0;
        for (int p = 0; p < P; p++) begin
            for (int b = 23; b >= 0; b--) begin
                h = 0;
                while (dout === 1'b1 && h <= TBIT) begin
                    h++; t++; tick();
                end
                if (h != T0H && h != T1H) terrs++;
                got_pix[p][b] = (h == T1H);
                if (!(p == P - 1 && b == 0)) begin
                    l = 0;
                    while (dout === 1'b0 && l <= TBIT) begin
                        l++; t++; tick();
                    end
                    if (h + l != TBIT) terrs++;
                end
            end
        end
        guard = 0;
        while (frame_done !== 1'b1 && guard < TBIT + TRESET + 10) begin
            if (dout !== 1'b0) terrs++;
            guard++; t++; tick();
        end
        if (frame_done === 1'b1) flen = t;
    endtask

    task automatic check_frame(input string tag);
        for (int p = 0; p < P; p++) begin
            n_checks++;
            if (got_pix[p] !== exp_pix[p]) begin
                n_fail++;
                $display("FAIL %s_pixel%0d: got %h, required %h", tag, p, got_pix[p], exp_pix[p]);
            end
        end
        n_checks++;
        if (timing_errs !== 0) begin
            n_fail++;
            $display("FAIL %s_bit_timing: %0d bad bit periods, required 0", tag, timing_errs);
        end
        n_checks++;
        if (frame_len !== FRAME_LAST) begin
            n_fail++;
            $display("FAIL %s_frame_len: frame_done at cycle %0d, required %0d", tag, frame_len, FRAME_LAST);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        write_readf = 1'b1;
        address     = a;
        write_data  = d;
        tick();
        write_readf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        n_checks++;
        if (dout !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: dout=%b busy=%b frame_done=%b, required 0 0 0", dout, busy, frame_done);
        end
        for (int a = 0; a < P; a++) begin
            address = 32'(a);
            tick();
            n_checks++;
            if (read_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read%0d: got %h, required 00000000", a, read_data);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_single_write();
        for (int p = 0; p < P; p++) exp_pix[p] = 24'h0;
        exp_pix[3] = 24'hA50F01;
        do_write(32'd3, 32'h00A50F01);
        tick();
        n_checks++;
        if (read_data !== 32'h00A50F01) begin
            n_fail++;
            $display("FAIL single_read: got %h, required 00a50f01", read_data);
        end
        capture_frame(frame_len, timing_errs, rise_wait);
        n_checks++;
        if (rise_wait !== 1) begin
            n_fail++;
            $display("FAIL single_latency: rise %0d cycles after read check, required 1", rise_wait);
        end
        check_frame("single");
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: frame_done=%b busy=%b, required 0 0", frame_done, busy);
        end
    endtask

    task automatic test_out_of_range();
        int busy_hits;
        busy_hits = 0;
        do_write(32'd12, 32'h00FFFFFF);
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b0) busy_hits++;
            tick();
        end
        n_checks++;
        if (busy_hits !== 0) begin
            n_fail++;
            $display("FAIL oor_busy: busy high %0d cycles, required 0", busy_hits);
        end
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read12: got %h, required 00000000", read_data);
        end
        address = 32'h0000_0103;
        tick();
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_alias: got %h, required 00000000", read_data);
        end
    endtask

    task automatic test_mid_frame_write();
        for (int p = 0; p < P; p++) exp_pix[p] = 24'h0;
        exp_pix[3]  = 24'hA50F01;
        exp_pix[5]  = 24'h123456;
        exp_pix[10] = 24'hFFFFFF;
        do_write(32'd5, 32'h00123456);
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_read_before_write: got %h, required 00000000", read_data);
        end
        fork
            capture_frame(frame_len, timing_errs, rise_wait);
            begin
                int w;
                w = 0;
                while (dout !== 1'b1 && w < 200) begin
                    w++;
                    tick();
                end
                repeat (900) tick();
                do_write(32'd10, 32'h00FFFFFF);
            end
        join
        check_frame("mid");
        tick();
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle_gap: busy=%b frame_done=%b, required 0 0", busy, frame_done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || dout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_second_load: busy=%b dout=%b, required 1 0", busy, dout);
        end
        tick();
        n_checks++;
        if (dout !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_second_rise: dout=%b, required 1", dout);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_hits, busy_hits;
        done_hits = 0;
        busy_hits = 0;
        repeat (5 * 24 * TBIT + 50) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (dout !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: dout=%b busy=%b frame_done=%b, required 0 0 0", dout, busy, frame_done);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (frame_done !== 1'b0) done_hits++;
            if (busy !== 1'b0) busy_hits++;
            tick();
        end
        n_checks++;
        if (done_hits !== 0 || busy_hits !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: frame_done %0d busy %0d cycles, required 0 0", done_hits, busy_hits);
        end
        address = 32'd3;
        tick();
        address = 32'd5;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_read3: got %h, required 00000000", read_data);
        end
        tick();
        address = 32'd10;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_read5: got %h, required 00000000", read_data);
        end
        tick();
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_read10: got %h, required 00000000", read_data);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_write();
        test_out_of_range();
        test_mid_frame_write();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
